// File: rtl/node_pkg.sv
// Shared definitions for the graph-colouring node: scan states, default sizes
// and the index-width helper used by the scanner and the array top.
package node_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NODE_W = 2;
    localparam int NODE_N = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/node_conflict_scanner_if.sv
// Start/busy/done handshake and result bus between a node controller and its
// neighbour-conflict scanner.
interface node_conflict_scanner_if
    import node_pkg::*;
#(
    parameter int W = NODE_W,
    parameter int N = NODE_N
);
    localparam int IW = idx_width(N);

    logic              start;
    logic [W-1:0]      self_val;
    logic [N*W-1:0]    nbr_vals;
    logic              busy;
    logic              done;
    logic              conflict;
    logic [N-1:0]      conflict_mask;
    logic [IW-1:0]     first_idx;

    modport master (
        output start, self_val, nbr_vals,
        input  busy, done, conflict, conflict_mask, first_idx
    );

    modport slave (
        input  start, self_val, nbr_vals,
        output busy, done, conflict, conflict_mask, first_idx
    );

endinterface

// File: rtl/node_eq_cmp.sv
// W-bit unsigned equality comparator, time-shared across the scan cycles.
module node_eq_cmp #(
    parameter int W = 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o
);
    assign eq_o = (a_i == b_i);
endmodule

// File: rtl/node_conflict_scanner.sv
// Sequential neighbour-conflict scanner: snapshots own and neighbour values, then
// checks one neighbour per cycle. Define NODE_SCAN_EARLY_EXIT_EN to stop at the first match.
module node_conflict_scanner
    import node_pkg::*;
#(
    parameter int W = NODE_W,
    parameter int N = NODE_N
) (
    input  logic                    clk,
    input  logic                    rst,
    node_conflict_scanner_if.slave  bus
);
    localparam int IW = idx_width(N);

    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       first_idx_q;
    logic [W-1:0]        snap_self_q;
    logic [N-1:0][W-1:0] snap_nbr_q;
    logic                busy_q;
    logic                done_q;
    logic                conflict_q;
    logic [N-1:0]        mask_q;

    logic [W-1:0]        cur_nbr_d;
    logic                match_d;
    logic                last_d;
    logic                stop_d;
    logic [N-1:0]        hit_d;

    assign cur_nbr_d = snap_nbr_q[idx_q];
    assign last_d    = (idx_q == IW'(N - 1));
    assign hit_d     = N'(1) << idx_q;

    node_eq_cmp #(.W(W)) u_cmp (
        .a_i  (snap_self_q),
        .b_i  (cur_nbr_d),
        .eq_o (match_d)
    );

`ifdef NODE_SCAN_EARLY_EXIT_EN
    assign stop_d = last_d | match_d;
`else
    assign stop_d = last_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            first_idx_q <= '0;
            snap_self_q <= '0;
            snap_nbr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            mask_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        snap_self_q <= bus.self_val;
                        snap_nbr_q  <= bus.nbr_vals;
                        mask_q      <= '0;
                        conflict_q  <= 1'b0;
                        first_idx_q <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (match_d) begin
                        mask_q     <= mask_q | hit_d;
                        conflict_q <= 1'b1;
                        // conflict_q still low means this is the first hit of the scan
                        if (!conflict_q) first_idx_q <= idx_q;
                    end
                    if (stop_d) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.conflict      = conflict_q;
    assign bus.conflict_mask = mask_q;
    assign bus.first_idx     = first_idx_q;

endmodule

// File: tb/tb_node_conflict_scanner.sv
// Directed bench for node_conflict_scanner (W=2/N=4 instance plus a W=1/N=1 instance).
module tb_node_conflict_scanner;

`ifdef NODE_SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    node_conflict_scanner_if #(.W(2), .N(4)) ifa ();
    node_conflict_scanner_if #(.W(1), .N(1)) ifb ();

    node_conflict_scanner #(.W(2), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    node_conflict_scanner #(.W(1), .N(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one scan on the 2x4 instance and return edges from accept to done (-1 on timeout).
    task automatic run_scan(input logic [1:0] s, input logic [7:0] nv,
                            output int lat, output logic busy0);
        @(posedge clk); #1;
        ifa.start    = 1'b1;
        ifa.self_val = s;
        ifa.nbr_vals = nv;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        busy0 = ifa.busy;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ifa.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.self_val = '0; ifa.nbr_vals = '0;
        ifb.start = 1'b0; ifb.self_val = '0; ifb.nbr_vals = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifa.busy, ifa.done, ifa.conflict, ifa.conflict_mask, ifa.first_idx} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {ifa.busy, ifa.done, ifa.conflict, ifa.conflict_mask, ifa.first_idx});
        end
        n_cmp++;
        if ({ifb.busy, ifb.done, ifb.conflict, ifb.conflict_mask, ifb.first_idx} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_outputs_n1: got %b expected 0",
                     {ifb.busy, ifb.done, ifb.conflict, ifb.conflict_mask, ifb.first_idx});
        end
        rst = 1'b0;
    endtask

    task automatic test_no_conflict;
        int lat; logic b0;
        run_scan(2'b11, {2'd0, 2'd2, 2'd1, 2'd0}, lat, b0);
        n_cmp++;
        if (b0 !== 1'b1) begin n_err++; $display("FAIL noconf_busy: got %b expected 1", b0); end
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL noconf_latency: got %0d expected 4", lat); end
        n_cmp++;
        if ({ifa.conflict, ifa.conflict_mask, ifa.first_idx} !== 7'd0) begin
            n_err++;
            $display("FAIL noconf_result: got conf=%b mask=%b idx=%0d expected 0/0000/0",
                     ifa.conflict, ifa.conflict_mask, ifa.first_idx);
        end
        n_cmp++;
        if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL noconf_busy_in_done: got %b expected 1", ifa.busy); end
    endtask

    task automatic test_multi_conflict;
        int lat; logic b0;
        logic [3:0] exp_mask;
        int exp_lat;
        exp_mask = EE ? 4'b0010 : 4'b1010;
        exp_lat  = EE ? 2 : 4;
        run_scan(2'b10, {2'd2, 2'd3, 2'd2, 2'd1}, lat, b0);
        n_cmp++;
        if (lat !== exp_lat) begin n_err++; $display("FAIL multi_latency: got %0d expected %0d", lat, exp_lat); end
        n_cmp++;
        if (ifa.conflict_mask !== exp_mask) begin
            n_err++; $display("FAIL multi_mask: got %b expected %b", ifa.conflict_mask, exp_mask);
        end
        n_cmp++;
        if (ifa.conflict !== 1'b1) begin n_err++; $display("FAIL multi_conflict: got %b expected 1", ifa.conflict); end
        n_cmp++;
        if (ifa.first_idx !== 2'd1) begin n_err++; $display("FAIL multi_first_idx: got %0d expected 1", ifa.first_idx); end
        // results must hold once the block is back in IDLE
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ifa.busy, ifa.done, ifa.conflict_mask, ifa.first_idx} !== {1'b0, 1'b0, exp_mask, 2'd1}) begin
            n_err++;
            $display("FAIL multi_hold: got busy=%b done=%b mask=%b idx=%0d expected 0 0 %b 1",
                     ifa.busy, ifa.done, ifa.conflict_mask, ifa.first_idx, exp_mask);
        end
    endtask

    task automatic test_all_match;
        int lat; logic b0;
        logic [3:0] exp_mask;
        int exp_lat;
        exp_mask = EE ? 4'b0001 : 4'b1111;
        exp_lat  = EE ? 1 : 4;
        run_scan(2'b00, 8'h00, lat, b0);
        n_cmp++;
        if (lat !== exp_lat) begin n_err++; $display("FAIL allmatch_latency: got %0d expected %0d", lat, exp_lat); end
        n_cmp++;
        if ({ifa.conflict, ifa.conflict_mask, ifa.first_idx} !== {1'b1, exp_mask, 2'd0}) begin
            n_err++;
            $display("FAIL allmatch_result: got conf=%b mask=%b idx=%0d expected 1 %b 0",
                     ifa.conflict, ifa.conflict_mask, ifa.first_idx, exp_mask);
        end
    endtask

    task automatic test_snapshot;
        int lat;
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.self_val = 2'd1; ifa.nbr_vals = 8'h00;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifa.nbr_vals = 8'h10;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ifa.done) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL snap_latency: got %0d expected 4", lat); end
        n_cmp++;
        if ({ifa.conflict, ifa.conflict_mask} !== 5'd0) begin
            n_err++; $display("FAIL snap_isolation: got conf=%b mask=%b expected 0 0000", ifa.conflict, ifa.conflict_mask);
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        int d_at [2];
        logic [6:0] res1;
        logic drained;
        dones = 0; d_at[0] = -1; d_at[1] = -1; res1 = '0;
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.self_val = 2'd1; ifa.nbr_vals = {2'd1, 2'd0, 2'd0, 2'd0};
        @(posedge clk); #1;
        ifa.self_val = 2'd3; ifa.nbr_vals = {2'd3, 2'd0, 2'd0, 2'd0};
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ifa.done) begin
                if (dones < 2) d_at[dones] = k;
                if (dones == 0) res1 = {ifa.conflict, ifa.conflict_mask, ifa.first_idx};
                dones++;
            end
        end
        ifa.start = 1'b0;
        n_cmp++;
        if (dones !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        n_cmp++;
        if (d_at[0] !== 4 || d_at[1] !== 10) begin
            n_err++; $display("FAIL b2b_done_edges: got %0d,%0d expected 4,10", d_at[0], d_at[1]);
        end
        n_cmp++;
        if (res1 !== {1'b1, 4'b1000, 2'd3}) begin
            n_err++; $display("FAIL b2b_first_result: got %b expected 1_1000_11", res1);
        end
        drained = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!ifa.busy && !ifa.done) begin drained = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (drained !== 1'b1) begin n_err++; $display("FAIL b2b_drain: got busy=%b expected 0", ifa.busy); end
    endtask

    task automatic test_reset_midscan;
        logic seen_done;
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.self_val = 2'd3; ifa.nbr_vals = {2'd3, 2'd0, 2'd0, 2'd0};
        @(posedge clk); #1;
        ifa.start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL midscan_busy: got %b expected 1", ifa.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ifa.busy, ifa.done, ifa.conflict, ifa.conflict_mask, ifa.first_idx} !== 9'd0) begin
            n_err++;
            $display("FAIL midscan_reset: got %b expected 0",
                     {ifa.busy, ifa.done, ifa.conflict, ifa.conflict_mask, ifa.first_idx});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ifa.done || ifa.busy) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_err++; $display("FAIL midscan_no_done: got activity=%b expected 0", seen_done); end
    endtask

    task automatic test_degenerate;
        int lat;
        @(posedge clk); #1;
        ifb.start = 1'b1; ifb.self_val = 1'b1; ifb.nbr_vals = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ifb.done) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL n1_latency: got %0d expected 1", lat); end
        n_cmp++;
        if ({ifb.conflict, ifb.conflict_mask, ifb.first_idx} !== 3'b110) begin
            n_err++;
            $display("FAIL n1_result: got conf=%b mask=%b idx=%0d expected 1 1 0",
                     ifb.conflict, ifb.conflict_mask, ifb.first_idx);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_no_conflict();
        test_multi_conflict();
        test_all_match();
        test_snapshot();
        test_back_to_back();
        test_reset_midscan();
        test_no_conflict();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
